cla_subtractor_pipe: RTL and testbench

- Pipelined 16-bit carry-lookahead subtractor: computes diff = a - b - bin using the same parallel-prefix KPG network as our pipelined CLA adder, run in the borrow direction.
- One prefix level per pipeline stage, with a valid bit carried alongside the data, so a new operation can enter every cycle.
- Global stall freezes the whole pipe.
- Sits next to the CLA adder in the ALU datapath lab and shares its KPG package.

---
 rtl/cla_pkg.sv | 33 +++
 rtl/cla_subtractor_pipe_kpg_cell.sv | 21 ++
 rtl/cla_subtractor_pipe.sv | 188 ++++++++++++++++++
 tb/tb_cla_subtractor_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor pair.
// Carries the KPG (kill/propagate/generate) encoding, the default operand
// width and the latency helper, so that both datapaths agree on them.
package cla_pkg;

    // Two-bit KPG symbol carried through the prefix network
    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_K = 2'b00;
    localparam kpg_t KPG_P = 2'b01;
    localparam kpg_t KPG_G = 2'b10;

    localparam int CLA_DEFAULT_WIDTH = 16;

    // Input register + one register per prefix level + output register
    function automatic int cla_latency(input int w);
        return $clog2(w) + 2;
    endfunction

    // Classify a single bit position from its propagate/generate pair
    function automatic kpg_t kpg_encode(input logic p, input logic g);
        kpg_t sym;
        if (g) begin
            sym = KPG_G;
        end else if (p) begin
            sym = KPG_P;
        end else begin
            sym = KPG_K;
        end
        return sym;
    endfunction

endpackage

// File: rtl/cla_subtractor_pipe_kpg_cell.sv
// One node of the parallel-prefix network: merges the KPG symbol of a
// higher span (hi) with the symbol of the span directly below it (lo).
module kpg_cell
    import cla_pkg::*;
(
    input  kpg_t hi,
    input  kpg_t lo,
    output kpg_t out
);

    // A kill or generate above decides the carry; a propagate defers to lo
    always_comb begin
        out = KPG_K;
        case (hi)
            KPG_G:   out = KPG_G;
            KPG_P:   out = lo;
            default: out = KPG_K;
        endcase
    end

endmodule

// File: rtl/cla_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin, evaluated as
// a + ~b + ~bin through the same KPG prefix network as the CLA adder.
// One prefix level per stage, so a new operation may enter every cycle.
// Optional macro CLA_SUB_FLAGS_EN adds registered zero/neg/ovf flags;
// without it those outputs are constant 0 and no flag flops exist.
module cla_subtractor_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    // WIDTH is expected to be a power of two, at least 4
    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = cla_latency(WIDTH);

    // Entry 0 of every KPG vector is the carry-in (bit -1); entry i+1 is bit i.
    // Index 0 of the outer dimension is the input register, index k is level k.
    kpg_t [LEVELS:0][WIDTH:0] kpg_q, kpg_d;
    logic [LEVELS:0][WIDTH-1:0] p_q, p_d;
    logic [LEVELS:0] cin_q, cin_d;
    kpg_t [LEVELS:1][WIDTH:0] lvl_comb;

    logic [LAT-1:0] valid_q, valid_d;

    logic [WIDTH-1:0] diff_q, diff_d, diff_calc;
    logic bout_q, bout_d, bout_calc;
    logic [WIDTH:0] carry;

    // Kogge-Stone combine network between consecutive prefix registers
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int D = 1 << (k - 1);
        for (genvar j = 0; j <= WIDTH; j++) begin : g_bit
            if (j >= D) begin : g_cell
                kpg_cell u_cell (
                    .hi  (kpg_q[k-1][j]),
                    .lo  (kpg_q[k-1][j-D]),
                    .out (lvl_comb[k][j])
                );
            end else begin : g_pass
                assign lvl_comb[k][j] = kpg_q[k-1][j];
            end
        end
    end

    // Input register and prefix levels advance together unless stalled
    always_comb begin
        kpg_d = kpg_q;
        p_d   = p_q;
        cin_d = cin_q;
        if (!stall) begin
            kpg_d[0][0] = bin ? KPG_K : KPG_G;
            for (int i = 0; i < WIDTH; i++) begin
                kpg_d[0][i+1] = kpg_encode(a[i] ^ ~b[i], a[i] & ~b[i]);
            end
            p_d[0]   = a ^ ~b;
            cin_d[0] = ~bin;
            for (int k = 1; k <= LEVELS; k++) begin
                kpg_d[k] = lvl_comb[k];
                p_d[k]   = p_q[k-1];
                cin_d[k] = cin_q[k-1];
            end
        end
    end

    // Resolve carries; entry WIDTH may still read P because its span stops
    // just short of the carry-in, so a remaining P takes the delayed cin
    always_comb begin
        carry = '0;
        for (int j = 0; j <= WIDTH; j++) begin
            carry[j] = (kpg_q[LEVELS][j] == KPG_G) |
                       ((kpg_q[LEVELS][j] == KPG_P) & cin_q[LEVELS]);
        end
        diff_calc = p_q[LEVELS] ^ carry[WIDTH-1:0];
        bout_calc = ~carry[WIDTH];
    end

    // Output register holds the previous result while stalled
    always_comb begin
        diff_d = diff_q;
        bout_d = bout_q;
        if (!stall) begin
            diff_d = diff_calc;
            bout_d = bout_calc;
        end
    end

    // Valid shift register mirrors the data stages one-for-one
    always_comb begin
        valid_d = valid_q;
        if (!stall) begin
            valid_d = {valid_q[LAT-2:0], in_valid};
        end
    end

    // All datapath and valid state clears immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kpg_q   <= '0;
            p_q     <= '0;
            cin_q   <= '0;
            valid_q <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            kpg_q   <= kpg_d;
            p_q     <= p_d;
            cin_q   <= cin_d;
            valid_q <= valid_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign diff      = diff_q;
    assign bout      = bout_q;

`ifdef CLA_SUB_FLAGS_EN

    // Operand sign bits travel with the data so overflow can be judged
    // against the final difference
    logic [LEVELS:0] msb_a_q, msb_a_d;
    logic [LEVELS:0] msb_b_q, msb_b_d;
    logic zero_q, zero_d;
    logic neg_q, neg_d;
    logic ovf_q, ovf_d;

    // Sign-bit delay line and flag computation, frozen by stall
    always_comb begin
        msb_a_d = msb_a_q;
        msb_b_d = msb_b_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        if (!stall) begin
            msb_a_d = {msb_a_q[LEVELS-1:0], a[WIDTH-1]};
            msb_b_d = {msb_b_q[LEVELS-1:0], b[WIDTH-1]};
            zero_d  = (diff_calc == '0);
            neg_d   = diff_calc[WIDTH-1];
            ovf_d   = (msb_a_q[LEVELS] != msb_b_q[LEVELS]) &&
                      (diff_calc[WIDTH-1] != msb_a_q[LEVELS]);
        end
    end

    // Flag registers share the datapath reset behaviour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_a_q <= '0;
            msb_b_q <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            msb_a_q <= msb_a_d;
            msb_b_q <= msb_b_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

`else

    assign zero = 1'b0;
    assign neg  = 1'b0;
    assign ovf  = 1'b0;

`endif

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Scoreboard bench for cla_subtractor_pipe: each accepted operation pushes
// its reference result; every fresh out_valid pops and compares, including
// how many cycles the result took relative to the stalls in between.
module tb_cla_subtractor_pipe;
    import cla_pkg::*;

    localparam int WIDTH = 16;
    localparam int LAT   = cla_latency(WIDTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             stall = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
        logic             neg;
        logic             ovf;
        int               cap_cycle;
        int               cap_stalls;
    } exp_t;

    exp_t sbq[$];
    exp_t last_exp;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int stall_total = 0;
    logic stall_at_edge = 1'b0;

    cla_subtractor_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .stall     (stall),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Edge bookkeeping: cycle number, stall history, stall seen at this edge
    always @(posedge clk) begin
        cycle         <= cycle + 1;
        stall_at_edge <= stall;
        if (stall && rst_n) begin
            stall_total <= stall_total + 1;
        end
    end

    // Reference subtraction done in WIDTH+1 bits; the top bit is the borrow
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mbin);
        exp_t e;
        logic [WIDTH:0] full;
        full = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
        e.diff = full[WIDTH-1:0];
        e.bout = full[WIDTH];
`ifdef CLA_SUB_FLAGS_EN
        e.zero = (full[WIDTH-1:0] == '0);
        e.neg  = full[WIDTH-1];
        e.ovf  = (ma[WIDTH-1] != mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
`else
        e.zero = 1'b0;
        e.neg  = 1'b0;
        e.ovf  = 1'b0;
`endif
        e.cap_cycle  = 0;
        e.cap_stalls = 0;
        return e;
    endfunction

    // Single comparison point: counts it and reports on mismatch
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs; an accepted operation goes to the scoreboard
    task automatic apply_stimulus(input logic v, input logic s, input logic [WIDTH-1:0] sa,
                                  input logic [WIDTH-1:0] sb, input logic sbin);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        stall    = s;
        a        = sa;
        b        = sb;
        bin      = sbin;
        if (v && !s && rst_n) begin
            e = model(sa, sb, sbin);
            e.cap_cycle  = cycle + 1;
            e.cap_stalls = stall_total;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0);
        end
    endtask

    // Bounded wait for the scoreboard to empty
    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) begin
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0);
        end
        check_output("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_output({tag, "_diff"}, 32'(diff), 32'd0);
        check_output({tag, "_bout"}, 32'(bout), 32'd0);
        check_output({tag, "_flags"}, 32'({zero, neg, ovf}), 32'd0);
    endtask

    // Output monitor: a fresh result after every unstalled edge with out_valid,
    // a held result (matching the last one popped) after stalled edges
    always @(negedge clk) begin
        exp_t e;
        int delta;
        int want_lat;
        if (rst_n && out_valid) begin
            if (!stall_at_edge) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $error("[TB] FAIL unexpected_output observed diff=0x%0h expected no output", diff);
                end else begin
                    e = sbq.pop_front();
                    delta    = cycle - e.cap_cycle;
                    want_lat = (LAT - 1) + (stall_total - e.cap_stalls);
                    check_output("diff", 32'(diff), 32'(e.diff));
                    check_output("bout", 32'(bout), 32'(e.bout));
                    check_output("zero", 32'(zero), 32'(e.zero));
                    check_output("neg", 32'(neg), 32'(e.neg));
                    check_output("ovf", 32'(ovf), 32'(e.ovf));
                    check_output("latency", 32'(delta), 32'(want_lat));
                    last_exp = e;
                end
            end else begin
                check_output("hold_diff", 32'(diff), 32'(last_exp.diff));
                check_output("hold_bout", 32'(bout), 32'(last_exp.bout));
            end
        end
    end

    // Directed sequence: reset, corner cases, random stream, stall, reset flush
    initial begin
        #12;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(1'b1, 1'b0, 16'h1234, 16'h0034, 1'b0);
        idle(LAT + 2);

        apply_stimulus(1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h0005, 16'h0004, 1'b1);
        apply_stimulus(1'b1, 1'b0, 16'h8000, 16'h0001, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h7FFF, 16'hFFFF, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
        apply_stimulus(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        idle(LAT + 2);

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        idle(LAT + 2);

        apply_stimulus(1'b1, 1'b0, 16'h1111, 16'h0222, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h0100, 16'h0200, 1'b1);
        apply_stimulus(1'b1, 1'b0, 16'hABCD, 16'h1234, 1'b1);
        apply_stimulus(1'b1, 1'b0, 16'h4000, 16'hC000, 1'b0);
        idle(3);
        apply_stimulus(1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b0);
        apply_stimulus(1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 16'h5555, 16'hAAAA, 1'b0);
        wait_drain(40);

        apply_stimulus(1'b1, 1'b0, 16'h0101, 16'h0010, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h2020, 16'h0303, 1'b1);
        apply_stimulus(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sbq.delete();
        #1;
        check_cleared("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0);
            check_output("no_stale_valid", 32'(out_valid), 32'd0);
        end

        apply_stimulus(1'b1, 1'b0, 16'h0042, 16'h0043, 1'b0);
        wait_drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
